// File: rtl/comm_pkg.sv
// rtl/comm_pkg.sv - shared opcodes, response codes, header layout and FSM states
package comm_pkg;

    typedef enum logic [7:0] {
        OP_WRITE = 8'h01,
        OP_READ  = 8'h02,
        OP_PING  = 8'h03
    } opcode_e;

    localparam logic [7:0] RSP_WRITE_OK = 8'h81;
    localparam logic [7:0] RSP_READ_OK  = 8'h82;
    localparam logic [7:0] RSP_PING     = 8'h83;
    localparam logic [7:0] RSP_ERR      = 8'hFF;

    typedef struct packed {
        logic [7:0]  opcode;
        logic [7:0]  tag;
        logic [15:0] addr;
        logic [31:0] count;
    } hdr_t;

    typedef enum logic [2:0] {
        ST_HDR,
        ST_WDATA,
        ST_WDROP,
        ST_RSP,
        ST_RDATA
    } state_e;

    // Response header word; fields a given code does not report are zeroed.
    function automatic logic [63:0] build_rsp(input logic [7:0] code, input logic [7:0] tag,
                                              input logic [15:0] addr, input logic [31:0] count,
                                              input logic [15:0] dev_id);
        case (code)
            RSP_WRITE_OK: build_rsp = {code, tag, 16'h0, count};
            RSP_READ_OK:  build_rsp = {code, tag, addr, count};
            RSP_PING:     build_rsp = {code, tag, dev_id, 32'h0};
            default:      build_rsp = {RSP_ERR, tag, 16'h0, 32'h0};
        endcase
    endfunction

endpackage

// File: rtl/comm_reg_responder_if.sv
// rtl/comm_reg_responder_if.sv - request/response stream bundle between host and responder
interface comm_reg_responder_if;
    logic [63:0] req_data;
    logic        req_valid;
    logic        req_ready;
    logic [63:0] rsp_data;
    logic        rsp_valid;
    logic        rsp_ready;

    modport master (output req_data, req_valid, rsp_ready,
                    input  req_ready, rsp_data, rsp_valid);
    modport slave  (input  req_data, req_valid, rsp_ready,
                    output req_ready, rsp_data, rsp_valid);
endinterface

// File: rtl/comm_reg_file.sv
// rtl/comm_reg_file.sv - NREGS x 64 register array, one sync write port, one comb read port
module comm_reg_file #(
    parameter int NREGS = 16,
    parameter int AW    = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [63:0]   wr_data,
    input  logic [AW-1:0] rd_addr,
    output logic [63:0]   rd_data
);
    logic [63:0] regs [NREGS];

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
        end else if (wr_en) begin
            regs[wr_addr] <= wr_data;
        end
    end

    assign rd_data = regs[rd_addr];
endmodule

// File: rtl/comm_reg_responder.sv
// rtl/comm_reg_responder.sv - host-stream register responder; COMM_RESP_STATS_EN adds request/error counters
module comm_reg_responder
    import comm_pkg::*;
#(
    parameter int          NREGS  = 16,
    parameter logic [15:0] DEV_ID = 16'h5A01
) (
    input  logic                clk,
    input  logic                reset,
    comm_reg_responder_if.slave bus,
    output logic [15:0]         req_count,
    output logic [15:0]         err_count
);
    localparam int AW = (NREGS > 1) ? $clog2(NREGS) : 1;

    state_e      state, state_nx;
    hdr_t        hdr;
    logic [7:0]  tag_q, code_q;
    logic [15:0] addr_q;
    logic [31:0] count_q, idx_q;
    logic        req_fire, rsp_fire, last_word;
    logic        is_wr, is_rd, is_ping, range_err, hdr_err;
    logic [32:0] end_addr;
    logic [7:0]  code_nx;
    logic [AW-1:0] word_addr;
    logic [63:0] rd_data;

    assign hdr = bus.req_data;

    // Ready is masked by reset so no word is accepted while the block is being cleared.
    assign bus.req_ready = reset && (state == ST_HDR || state == ST_WDATA || state == ST_WDROP);
    assign bus.rsp_valid = (state == ST_RSP || state == ST_RDATA);
    assign req_fire      = bus.req_valid && bus.req_ready;
    assign rsp_fire      = bus.rsp_valid && bus.rsp_ready;
    assign last_word     = (idx_q == count_q - 32'd1);

    assign is_wr     = (hdr.opcode == OP_WRITE);
    assign is_rd     = (hdr.opcode == OP_READ);
    assign is_ping   = (hdr.opcode == OP_PING);
    assign end_addr  = {17'h0, hdr.addr} + {1'b0, hdr.count};
    assign range_err = (end_addr > 33'(NREGS));
    assign hdr_err   = !(is_wr || is_rd || is_ping) ||
                       ((is_wr || is_rd) && (hdr.count == 32'h0 || range_err));

    always_comb begin
        code_nx = RSP_ERR;
        if (!hdr_err) begin
            if (is_wr)      code_nx = RSP_WRITE_OK;
            else if (is_rd) code_nx = RSP_READ_OK;
            else            code_nx = RSP_PING;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_HDR: if (req_fire) begin
                if (is_wr && !hdr_err)             state_nx = ST_WDATA;
                else if (is_wr && hdr.count != '0) state_nx = ST_WDROP;
                else                               state_nx = ST_RSP;
            end
            ST_WDATA, ST_WDROP: if (req_fire && last_word) state_nx = ST_RSP;
            ST_RSP: if (rsp_fire) state_nx = (code_q == RSP_READ_OK) ? ST_RDATA : ST_HDR;
            ST_RDATA: if (rsp_fire && last_word) state_nx = ST_HDR;
            default: state_nx = ST_HDR;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state   <= ST_HDR;
            tag_q   <= '0;
            code_q  <= '0;
            addr_q  <= '0;
            count_q <= '0;
            idx_q   <= '0;
        end else begin
            state <= state_nx;
            if (state == ST_HDR && req_fire) begin
                tag_q   <= hdr.tag;
                addr_q  <= hdr.addr;
                count_q <= hdr.count;
                code_q  <= code_nx;
                idx_q   <= '0;
            end else if ((state == ST_WDATA || state == ST_WDROP) && req_fire) begin
                idx_q <= last_word ? '0 : idx_q + 32'd1;
            end else if (state == ST_RDATA && rsp_fire) begin
                idx_q <= idx_q + 32'd1;
            end
        end
    end

    // Range check guarantees addr+idx < NREGS, so truncation to AW bits is exact.
    assign word_addr = AW'(addr_q) + AW'(idx_q);

    comm_reg_file #(.NREGS(NREGS), .AW(AW)) u_reg_file (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (state == ST_WDATA && req_fire),
        .wr_addr (word_addr),
        .wr_data (bus.req_data),
        .rd_addr (word_addr),
        .rd_data (rd_data)
    );

    always_comb begin
        bus.rsp_data = '0;
        if (state == ST_RSP)        bus.rsp_data = build_rsp(code_q, tag_q, addr_q, count_q, DEV_ID);
        else if (state == ST_RDATA) bus.rsp_data = rd_data;
    end

`ifdef COMM_RESP_STATS_EN
    always_ff @(posedge clk) begin
        if (!reset) begin
            req_count <= '0;
            err_count <= '0;
        end else begin
            if (state == ST_HDR && req_fire && req_count != 16'hFFFF)
                req_count <= req_count + 16'd1;
            if (state == ST_RSP && rsp_fire && code_q == RSP_ERR && err_count != 16'hFFFF)
                err_count <= err_count + 16'd1;
        end
    end
`else
    assign req_count = '0;
    assign err_count = '0;
`endif

endmodule

// File: tb/tb_comm_reg_responder.sv
// tb/tb_comm_reg_responder.sv - directed vector bench for comm_reg_responder
module tb_comm_reg_responder;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [15:0] req_count, err_count;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    comm_reg_responder_if bus ();

    comm_reg_responder #(.NREGS(16), .DEV_ID(16'h5A01)) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .req_count (req_count),
        .err_count (err_count)
    );

    typedef struct {
        bit          is_req;
        logic [63:0] word;
    } vec_t;

    vec_t tbl[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic send_req(input logic [63:0] w);
        bit done = 0;
        @(negedge clk);
        bus.req_data  = w;
        bus.req_valid = 1'b1;
        for (int n = 0; n < 50 && !done; n++) begin
            if (bus.req_ready) begin
                @(posedge clk);
                done = 1;
            end else begin
                @(negedge clk);
            end
        end
        #1 bus.req_valid = 1'b0;
        check("req_accepted", 64'(done), 64'd1);
    endtask

    task automatic recv_rsp(input string name, input logic [63:0] exp);
        bit done = 0;
        @(negedge clk);
        bus.rsp_ready = 1'b1;
        for (int n = 0; n < 50 && !done; n++) begin
            if (bus.rsp_valid) begin
                check(name, bus.rsp_data, exp);
                @(posedge clk);
                done = 1;
            end else begin
                @(negedge clk);
            end
        end
        #1 bus.rsp_ready = 1'b0;
        check({name, "_seen"}, 64'(done), 64'd1);
    endtask

    task automatic add(input bit r, input logic [63:0] w);
        vec_t v;
        v.is_req = r;
        v.word   = w;
        tbl.push_back(v);
    endtask

    initial begin
        logic [63:0] exp_words [3];
        logic [63:0] prev_data;
        bit          ready_ph, prev_stall;
        int          k;

        bus.req_data  = '0;
        bus.req_valid = 1'b0;
        bus.rsp_ready = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_req_ready", 64'(bus.req_ready), 64'd0);
        check("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        check("rst_rsp_data", bus.rsp_data, 64'd0);
        check("rst_req_count", 64'(req_count), 64'd0);
        check("rst_err_count", 64'(err_count), 64'd0);
        reset = 1'b1;
        @(negedge clk);
        check("hdr_req_ready", 64'(bus.req_ready), 64'd1);

        // Write two words, response one cycle after last data word
        send_req(64'h0107_0002_0000_0002);
        send_req(64'hA);
        send_req(64'hB);
        @(negedge clk);
        check("rsp_latency", 64'(bus.rsp_valid), 64'd1);
        recv_rsp("wr_rsp", 64'h8107_0000_0000_0002);

        // Read back with rsp_ready toggling: order and stall stability
        send_req(64'h0208_0002_0000_0002);
        exp_words[0] = 64'h8208_0002_0000_0002;
        exp_words[1] = 64'hA;
        exp_words[2] = 64'hB;
        k = 0; ready_ph = 0; prev_stall = 0; prev_data = '0;
        for (int c = 0; c < 60 && k < 3; c++) begin
            @(negedge clk);
            if (prev_stall) begin
                check("stall_valid", 64'(bus.rsp_valid), 64'd1);
                check("stall_data", bus.rsp_data, prev_data);
            end
            ready_ph = ~ready_ph;
            bus.rsp_ready = ready_ph;
            prev_stall = 0;
            if (bus.rsp_valid) begin
                if (ready_ph) begin
                    check("toggle_word", bus.rsp_data, exp_words[k]);
                    k++;
                end else begin
                    prev_stall = 1;
                    prev_data  = bus.rsp_data;
                end
            end
        end
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        check("toggle_count", 64'(k), 64'd3);

        // Table: range errors, count==0, boundary write/read, no-wrap
        add(1, 64'h0109_000F_0000_0002); add(1, 64'h1); add(1, 64'h2);
        add(0, 64'hFF09_0000_0000_0000);
        add(1, 64'h020B_000E_0000_0002);
        add(0, 64'h820B_000E_0000_0002); add(0, 64'h0); add(0, 64'h0);
        add(1, 64'h020C_0002_0000_0002);
        add(0, 64'h820C_0002_0000_0002); add(0, 64'hA); add(0, 64'hB);
        add(1, 64'h010E_0000_0000_0000); add(0, 64'hFF0E_0000_0000_0000);
        add(1, 64'h020F_0000_0000_0000); add(0, 64'hFF0F_0000_0000_0000);
        add(1, 64'h0110_000E_0000_0002); add(1, 64'h11); add(1, 64'h22);
        add(0, 64'h8110_0000_0000_0002);
        add(1, 64'h0111_FFFF_0000_0002); add(1, 64'h33); add(1, 64'h44);
        add(0, 64'hFF11_0000_0000_0000);
        add(1, 64'h0212_000E_0000_0002);
        add(0, 64'h8212_000E_0000_0002); add(0, 64'h11); add(0, 64'h22);
        add(1, 64'h0213_0010_0000_0001); add(0, 64'hFF13_0000_0000_0000);
        foreach (tbl[i]) begin
            if (tbl[i].is_req) send_req(tbl[i].word);
            else recv_rsp($sformatf("vec%0d", i), tbl[i].word);
        end

        // Reset in the middle of a 4-word read
        send_req(64'h0120_0000_0000_0004);
        send_req(64'h1); send_req(64'h2); send_req(64'h3); send_req(64'h4);
        recv_rsp("w4_rsp", 64'h8120_0000_0000_0004);
        send_req(64'h0221_0000_0000_0004);
        recv_rsp("r4_rsp", 64'h8221_0000_0000_0004);
        recv_rsp("r4_d0", 64'h1);
        recv_rsp("r4_d1", 64'h2);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("mid_rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        check("mid_rst_req_ready", 64'(bus.req_ready), 64'd0);
        reset = 1'b1;
        @(negedge clk);
        check("post_rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        check("post_rst_req_ready", 64'(bus.req_ready), 64'd1);
        send_req(64'h0222_0000_0000_0004);
        recv_rsp("clr_rsp", 64'h8222_0000_0000_0004);
        for (int i = 0; i < 4; i++) recv_rsp($sformatf("clr_d%0d", i), 64'h0);

        // Fresh statistics window: ping plus bad opcode
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        send_req(64'h030A_0000_0000_0000);
        recv_rsp("ping", 64'h830A_5A01_0000_0000);
        send_req(64'h5530_0000_0000_0000);
        recv_rsp("bad_op", 64'hFF30_0000_0000_0000);
        @(negedge clk);
`ifdef COMM_RESP_STATS_EN
        check("req_count", 64'(req_count), 64'd2);
        check("err_count", 64'(err_count), 64'd1);
`else
        check("req_count_off", 64'(req_count), 64'd0);
        check("err_count_off", 64'(err_count), 64'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running expected=finished");
        $fatal(1);
    end
endmodule
